jump_input_ctrl: RTL and testbench

//  Upstream of the character stage: turns raw left/right player buttons into clean jump_left/jump_right pulses.

---
 rtl/jump_input_ctrl_pkg.sv | 22 ++
 rtl/jump_input_ctrl_if.sv | 22 ++
 rtl/jump_input_ctrl_btn_debounce.sv | 56 +++++
 rtl/jump_input_ctrl.sv | 129 ++++++++++++
 tb/tb_jump_input_ctrl.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/jump_input_ctrl_pkg.sv
// Shared constants and types for the jump input controller: jump directions,
// FSM state encodings and the one-entry pending request record.
package jump_input_ctrl_pkg;

  localparam logic JUMP_DIR_LEFT  = 1'b0;
  localparam logic JUMP_DIR_RIGHT = 1'b1;

  localparam logic [1:0] S_READY     = 2'd0;
  localparam logic [1:0] S_ISSUE     = 2'd1;
  localparam logic [1:0] S_WAIT_LAND = 2'd2;

  typedef struct packed {
    logic valid;
    logic dir;
  } pend_t;

  // Left wins whenever both buttons produce an edge in the same cycle.
  function automatic logic press_dir(input logic press_left);
    return press_left ? JUMP_DIR_LEFT : JUMP_DIR_RIGHT;
  endfunction

endpackage

// File: rtl/jump_input_ctrl_if.sv
// Button/landing inputs and jump request outputs of the jump input controller.
interface jump_input_ctrl_if;
  logic module_en;
  logic btn_left;
  logic btn_right;
  logic one_ms_tick;
  logic landed;
  logic jump_left;
  logic jump_right;
  logic busy;
  logic timeout_err;

  modport master (
    output module_en, btn_left, btn_right, one_ms_tick, landed,
    input  jump_left, jump_right, busy, timeout_err
  );

  modport slave (
    input  module_en, btn_left, btn_right, one_ms_tick, landed,
    output jump_left, jump_right, busy, timeout_err
  );
endinterface

// File: rtl/jump_input_ctrl_btn_debounce.sv
// One button channel: synchroniser chain, 1 ms tick debounce and rising-edge
// detection of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic tick_i,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_MS - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   deb_q, deb_d;
  logic                   deb_dly_q;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_i};
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    // The counter only moves on ticks; any agreement restarts the stability run.
    if (tick_i) begin
      if (sync_q[SYNC_STAGES-1] == deb_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        deb_d = ~deb_q;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      cnt_q     <= '0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      cnt_q     <= cnt_d;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
    end
  end

  assign press_o = deb_q & ~deb_dly_q;

endmodule

// File: rtl/jump_input_ctrl.sv
// Jump request controller: arbitrates debounced button presses into single
// registered jump pulses, holds one buffered press and guards the landing wait.
module jump_input_ctrl
  import jump_input_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_MS = 10,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_MS  = 120
) (
  input  logic             clk,
  input  logic             rst,
  jump_input_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_MS - 1);

  logic          press_left_s, press_right_s, new_press_s, new_dir_s;
  logic [1:0]    state_q, state_d;
  pend_t         pend_q, pend_d, pend_nx_s;
  logic          dir_q, dir_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          jump_left_q, jump_left_d, jump_right_q, jump_right_d;
  logic          busy_q, busy_d, err_q, err_d;

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)) u_left (
    .clk(clk), .rst(rst), .btn_i(bus.btn_left), .tick_i(bus.one_ms_tick), .press_o(press_left_s)
  );

  btn_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS), .SYNC_STAGES(SYNC_STAGES)) u_right (
    .clk(clk), .rst(rst), .btn_i(bus.btn_right), .tick_i(bus.one_ms_tick), .press_o(press_right_s)
  );

  assign new_press_s = press_left_s | press_right_s;
  assign new_dir_s   = press_dir(press_left_s);

  always_comb begin
    state_d   = state_q;
    pend_nx_s = pend_q;
    dir_d     = dir_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    case (state_q)
      S_READY: begin
        // A buffered press goes first; a fresh press arriving now takes its slot.
        if (bus.module_en && (pend_q.valid || new_press_s)) begin
          state_d = S_ISSUE;
          if (pend_q.valid) begin
            dir_d     = pend_q.dir;
            pend_nx_s = '{valid: new_press_s, dir: new_dir_s};
          end else begin
            dir_d = new_dir_s;
          end
        end else begin
          state_d = S_READY;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_LAND;
        tmo_d   = '0;
        if (new_press_s) begin
          pend_nx_s = '{valid: 1'b1, dir: new_dir_s};
        end else begin
          pend_nx_s = pend_q;
        end
      end
      S_WAIT_LAND: begin
        if (new_press_s) begin
          pend_nx_s = '{valid: 1'b1, dir: new_dir_s};
        end else begin
          pend_nx_s = pend_q;
        end
        if (bus.landed) begin
          state_d = S_READY;
        end else if (bus.one_ms_tick) begin
          if (tmo_q == TMO_LAST) begin
            state_d = S_READY;
            err_d   = 1'b1;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end else begin
          tmo_d = tmo_q;
        end
      end
      default: begin
        state_d   = S_READY;
        pend_nx_s = '0;
      end
    endcase

    if (bus.module_en) begin
      pend_d = pend_nx_s;
    end else begin
      pend_d = '0;
    end

    jump_left_d  = (state_q == S_ISSUE) && (dir_q == JUMP_DIR_LEFT);
    jump_right_d = (state_q == S_ISSUE) && (dir_q == JUMP_DIR_RIGHT);
    busy_d       = (state_d != S_READY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_READY;
      pend_q       <= '0;
      dir_q        <= JUMP_DIR_LEFT;
      tmo_q        <= '0;
      jump_left_q  <= 1'b0;
      jump_right_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      dir_q        <= dir_d;
      tmo_q        <= tmo_d;
      jump_left_q  <= jump_left_d;
      jump_right_q <= jump_right_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign bus.jump_left   = jump_left_q;
  assign bus.jump_right  = jump_right_q;
  assign bus.busy        = busy_q;
  assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_jump_input_ctrl.sv
// Directed bench for jump_input_ctrl: expected jumps are queued as stimulus is
// applied and matched against jump pulses captured by a negedge monitor.
module tb_jump_input_ctrl;
  localparam int DEB = 10;
  localparam int TMO = 120;
  localparam int P   = 10;

  localparam int REF_NONE  = 0;
  localparam int REF_PRESS = 1;
  localparam int REF_LAND  = 2;

  typedef struct {
    logic dir;
    int   kind;
    int   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  jump_input_ctrl_if bif ();

  jump_input_ctrl #(.DEBOUNCE_MS(DEB), .SYNC_STAGES(2), .TIMEOUT_MS(TMO)) dut (
    .clk(clk), .rst(rst), .bus(bif)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    bif.one_ms_tick = 1'b0;
    forever begin
      repeat (P - 1) @(posedge clk);
      #1 bif.one_ms_tick = 1'b1;
      @(posedge clk);
      #1 bif.one_ms_tick = 1'b0;
    end
  end

  // Monitor: records every jump pulse with its distance to the last press edge and landed pulse.
  logic obs_dir    [0:255];
  logic obs_both   [0:255];
  logic obs_consec [0:255];
  int   obs_dp     [0:255];
  int   obs_dl     [0:255];
  int   obs_n      = 0;
  int   last_p     = 0;
  int   last_l     = 0;
  logic prev_j     = 1'b0;

  always @(negedge clk) begin
    if (dut.press_left_s || dut.press_right_s) last_p <= cyc;
    if (bif.landed) last_l <= cyc;
    prev_j <= bif.jump_left | bif.jump_right;
    if ((bif.jump_left || bif.jump_right) && obs_n < 256) begin
      obs_dir[obs_n]    <= bif.jump_right;
      obs_both[obs_n]   <= bif.jump_left & bif.jump_right;
      obs_consec[obs_n] <= prev_j;
      obs_dp[obs_n]     <= cyc - last_p;
      obs_dl[obs_n]     <= cyc - last_l;
      obs_n             <= obs_n + 1;
    end
  end

  exp_t exp_q[$];
  int   rd_idx = 0;
  int   n_cmp  = 0;
  int   n_err  = 0;

  task automatic check_int(input string tag, input int obs, input int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic l, input logic r, input int ms);
    bif.btn_left  = l;
    bif.btn_right = r;
    step(ms * P);
    bif.btn_left  = 1'b0;
    bif.btn_right = 1'b0;
    step((DEB + 3) * P);
  endtask

  task automatic pulse_landed();
    bif.landed = 1'b1;
    step(1);
    bif.landed = 1'b0;
  endtask

  task automatic expect_jump(input logic dir, input int kind, input int lat);
    exp_t e;
    e.dir  = dir;
    e.kind = kind;
    e.lat  = lat;
    exp_q.push_back(e);
  endtask

  // Scoreboard: pop one expectation per captured jump, then demand nothing is left over.
  task automatic drain(input string tag);
    exp_t e;
    while (rd_idx < obs_n) begin
      check_int({tag, "_both"}, int'(obs_both[rd_idx]), 0);
      check_int({tag, "_consec"}, int'(obs_consec[rd_idx]), 0);
      check_int({tag, "_unexpected"}, int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_int({tag, "_dir"}, int'(obs_dir[rd_idx]), int'(e.dir));
        if (e.kind == REF_PRESS) check_int({tag, "_lat_press"}, obs_dp[rd_idx], e.lat);
        if (e.kind == REF_LAND)  check_int({tag, "_lat_landed"}, obs_dl[rd_idx], e.lat);
      end
      rd_idx++;
    end
    check_int({tag, "_missing"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int found;
    rst           = 1'b1;
    bif.module_en = 1'b0;
    bif.btn_left  = 1'b0;
    bif.btn_right = 1'b0;
    bif.landed    = 1'b0;
    step(4);
    check_int("rst_jump_left", int'(bif.jump_left), 0);
    check_int("rst_jump_right", int'(bif.jump_right), 0);
    check_int("rst_busy", int'(bif.busy), 0);
    check_int("rst_timeout_err", int'(bif.timeout_err), 0);
    rst = 1'b0;
    bif.module_en = 1'b1;
    step(2 * P);

    // Clean left press: one pulse, two cycles after the press edge, busy until landed.
    expect_jump(1'b0, REF_PRESS, 2);
    hold(1'b1, 1'b0, 12);
    check_int("clean_busy_wait", int'(bif.busy), 1);
    drain("clean");
    pulse_landed();
    step(2);
    check_int("clean_busy_after_land", int'(bif.busy), 0);

    // Async reset in the middle of a landing wait with a right press buffered.
    expect_jump(1'b0, REF_PRESS, 2);
    hold(1'b1, 1'b0, 12);
    bif.btn_right = 1'b1;
    step(12 * P);
    bif.btn_right = 1'b0;
    check_int("rst_mid_busy_before", int'(bif.busy), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_int("rst_mid_busy", int'(bif.busy), 0);
    check_int("rst_mid_jump_left", int'(bif.jump_left), 0);
    check_int("rst_mid_jump_right", int'(bif.jump_right), 0);
    step(3);
    rst = 1'b0;
    step(30 * P);
    check_int("rst_after_busy", int'(bif.busy), 0);
    drain("reset");

    // Bouncing right button never settles for the debounce window.
    for (int i = 0; i < 10; i++) begin
      bif.btn_right = ~bif.btn_right;
      step(3 * P);
    end
    bif.btn_right = 1'b0;
    step(13 * P);
    drain("bounce");
    expect_jump(1'b1, REF_PRESS, 2);
    hold(1'b0, 1'b1, 11);
    drain("bounce_hold");
    pulse_landed();
    step(3);

    // Buffering: right then left pressed mid-wait; latest wins, issued after landed.
    expect_jump(1'b1, REF_PRESS, 2);
    hold(1'b0, 1'b1, 12);
    hold(1'b0, 1'b1, 12);
    hold(1'b1, 1'b0, 12);
    expect_jump(1'b0, REF_LAND, 3);
    pulse_landed();
    step(30 * P);
    check_int("buffer_busy", int'(bif.busy), 1);
    drain("buffer");
    pulse_landed();
    step(3);

    // Simultaneous edges resolve to left.
    expect_jump(1'b0, REF_PRESS, 2);
    hold(1'b1, 1'b1, 12);
    drain("simul");

    // Landed in the same cycle as a right press edge: press issued from S_READY next.
    bif.btn_right = 1'b1;
    found = 0;
    for (int i = 0; i < (DEB + 4) * P && found == 0; i++) begin
      @(negedge clk);
      if (bif.one_ms_tick && dut.u_right.cnt_q == DEB - 1 &&
          dut.u_right.sync_q[1] && !dut.u_right.deb_q) found = 1;
    end
    check_int("land_press_align", found, 1);
    expect_jump(1'b1, REF_LAND, 3);
    @(posedge clk);
    #1 pulse_landed();
    step(2 * P);
    bif.btn_right = 1'b0;
    step(13 * P);
    drain("land_press");
    pulse_landed();
    step(3);

    // Spurious landed in S_READY is ignored.
    pulse_landed();
    step(3);
    check_int("spurious_busy", int'(bif.busy), 0);

    // Timeout: no landed for TIMEOUT_MS ticks.
    expect_jump(1'b0, REF_PRESS, 2);
    hold(1'b1, 1'b0, 12);
    step((TMO - 30) * P);
    check_int("tmo_busy_before", int'(bif.busy), 1);
    check_int("tmo_err_before", int'(bif.timeout_err), 0);
    step(20 * P);
    check_int("tmo_busy_after", int'(bif.busy), 0);
    check_int("tmo_err_after", int'(bif.timeout_err), 1);
    drain("timeout");
    expect_jump(1'b1, REF_PRESS, 2);
    hold(1'b0, 1'b1, 12);
    drain("post_timeout");
    check_int("tmo_err_sticky", int'(bif.timeout_err), 1);
    pulse_landed();
    step(3);

    // Disabled: presses are dropped.
    bif.module_en = 1'b0;
    hold(1'b1, 1'b0, 12);
    step(5 * P);
    check_int("disabled_busy", int'(bif.busy), 0);
    drain("disabled");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
